// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and the data-memory store path.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREAD  = 2;

    // One byte lane of a byte-enabled merge: the new byte replaces the old one when enabled.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/regfile_param_dec.sv
// Binary-to-one-hot decoder with enable; all outputs are zero when disabled.
module dec_param #(
    parameter int ADDR_W = 5
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      sel,
    output logic [2**ADDR_W-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/regfile_param.sv
// Multi-port register file with byte-enable writes, write-through bypass and a
// per-register pending scoreboard used by decode to stall on RAW hazards.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int NREAD   = RF_NREAD,
    parameter int ZERO_R0 = 1
) (
    input  logic                      clk,
    input  logic                      clrn,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wn,
    input  logic [DATA_W/8-1:0]       wbe,
    input  logic [DATA_W-1:0]         d,
    input  logic [NREAD*ADDR_W-1:0]   rn,
    output logic [NREAD*DATA_W-1:0]   q,
    output logic [NREAD-1:0]          busy,
    input  logic                      iss,
    input  logic [ADDR_W-1:0]         iss_rd,
    input  logic                      flush
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NBYTE = DATA_W/8;

    logic [DATA_W-1:0] r [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [DEPTH-1:0]  wsel;
    logic [DEPTH-1:0]  isel;
    logic [DATA_W-1:0] wdata;

    dec_param #(.ADDR_W(ADDR_W)) u_wdec (.en(we),  .sel(wn),     .onehot(wsel));
    dec_param #(.ADDR_W(ADDR_W)) u_idec (.en(iss), .sel(iss_rd), .onehot(isel));

    // The merged write word doubles as the bypass value for same-cycle reads.
    for (genvar k = 0; k < NBYTE; k++) begin : g_merge
        assign wdata[8*k +: 8] = byte_merge(r[wn][8*k +: 8], d[8*k +: 8], wbe[k]);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) r[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i] && !(ZERO_R0 != 0 && i == 0)) r[i] <= wdata;
            end
        end
    end

    // Flush beats issue; a same-cycle issue beats the writeback clearing its register.
    always_comb begin
        pend_nxt = flush ? '0 : ((pend & ~wsel) | isel);
        if (ZERO_R0 != 0) pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) pend <= '0;
        else       pend <= pend_nxt;
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [ADDR_W-1:0] a;
        logic              hit;
        logic [DATA_W-1:0] qp;

        assign a   = rn[p*ADDR_W +: ADDR_W];
        assign hit = we && (wn == a);

        // Reset forces zero immediately so a write presented during reset cannot leak through.
        always_comb begin
            if (!clrn || (ZERO_R0 != 0 && a == '0)) qp = '0;
            else if (hit)                           qp = wdata;
            else                                    qp = r[a];
        end

        assign q[p*DATA_W +: DATA_W] = qp;
        assign busy[p] = clrn && pend[a] && !hit;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed vector table, async reset checks,
// and randomized traffic against an array-based reference model.
module tb_regfile_param;

    logic        clk;
    logic        clrn;
    logic        we;
    logic [4:0]  wn;
    logic [3:0]  wbe;
    logic [31:0] d;
    logic [9:0]  rn;
    logic [63:0] q;
    logic [1:0]  busy;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        flush;

    int tests;
    int fails;

    regfile_param dut (
        .clk(clk), .clrn(clrn), .we(we), .wn(wn), .wbe(wbe), .d(d),
        .rn(rn), .q(q), .busy(busy), .iss(iss), .iss_rd(iss_rd), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wn;
        logic [3:0]  wbe;
        logic [31:0] d;
        logic        iss;
        logic [4:0]  iss_rd;
        logic        flush;
        logic [4:0]  rn0;
        logic [4:0]  rn1;
        logic [31:0] q0;
        logic [31:0] q1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t vt[$];

    // Reference state
    logic [31:0] mreg  [32];
    logic        mpend [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [3:0] be,
                         input logic [31:0] dv, input logic i, input logic [4:0] ir,
                         input logic f, input logic [4:0] r0, input logic [4:0] r1);
        we = w; wn = a; wbe = be; d = dv; iss = i; iss_rd = ir; flush = f; rn = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 1'b0, r0, r1);
    endtask

    function automatic logic [31:0] model_q(input int a);
        logic [31:0] v;
        if (a == 0) return 32'h0;
        v = mreg[a];
        if (we && int'(wn) == a)
            for (int k = 0; k < 4; k++) if (wbe[k]) v[8*k +: 8] = d[8*k +: 8];
        return v;
    endfunction

    function automatic logic model_busy(input int a);
        return mpend[a] && !(we && int'(wn) == a);
    endfunction

    task automatic model_edge();
        if (we && wn != 5'd0) mreg[wn] = model_q(int'(wn));
        if (flush) begin
            for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
        end else begin
            if (we)  mpend[wn]     = 1'b0;
            if (iss) mpend[iss_rd] = 1'b1;
        end
        mpend[0] = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = 32'h0;
            mpend[i] = 1'b0;
        end
    endtask

    task automatic add(input logic w, input logic [4:0] a, input logic [3:0] be,
                       input logic [31:0] dv, input logic i, input logic [4:0] ir,
                       input logic f, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic eb0, input logic eb1);
        vec_t v;
        v.we = w; v.wn = a; v.wbe = be; v.d = dv; v.iss = i; v.iss_rd = ir; v.flush = f;
        v.rn0 = r0; v.rn1 = r1; v.q0 = e0; v.q1 = e1; v.b0 = eb0; v.b1 = eb1;
        vt.push_back(v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clrn = 1'b0;
        idle(5'd5, 5'd31);

        // Outputs zero while in reset, before any clock edge has occurred
        #2;
        check("reset_q0", q[31:0], 32'h0);
        check("reset_q1", q[63:32], 32'h0);
        check("reset_busy", {30'h0, busy}, 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // One row per cycle: inputs are applied on the falling edge and outputs checked before the rising edge
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  5, 31, 32'h0,        32'h0,        0, 0);
        add(1, 3, 4'hF, 32'h11223344, 0, 0, 0,  3,  3, 32'h11223344, 32'h11223344, 0, 0);
        add(1, 3, 4'h5, 32'hAABBCCDD, 0, 0, 0,  3,  3, 32'h11BB33DD, 32'h11BB33DD, 0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  3,  0, 32'h11BB33DD, 32'h0,        0, 0);
        add(1, 0, 4'hF, 32'hFFFFFFFF, 1, 0, 0,  0,  0, 32'h0,        32'h0,        0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  0,  3, 32'h0,        32'h11BB33DD, 0, 0);
        add(0, 0, 4'h0, 32'h0,        1, 7, 0,  7,  7, 32'h0,        32'h0,        0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  7,  3, 32'h0,        32'h11BB33DD, 1, 0);
        add(1, 7, 4'hF, 32'h0000005A, 0, 0, 0,  7,  7, 32'h0000005A, 32'h0000005A, 0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  7,  7, 32'h0000005A, 32'h0000005A, 0, 0);
        add(0, 0, 4'h0, 32'h0,        1, 9, 0,  9,  9, 32'h0,        32'h0,        0, 0);
        add(1, 9, 4'hF, 32'h00000001, 1, 9, 0,  9,  9, 32'h00000001, 32'h00000001, 0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  9,  7, 32'h00000001, 32'h0000005A, 1, 0);
        add(1, 9, 4'h0, 32'hFFFFFFFF, 0, 0, 0,  9,  9, 32'h00000001, 32'h00000001, 0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  9,  9, 32'h00000001, 32'h00000001, 0, 0);
        add(0, 0, 4'h0, 32'h0,        1, 2, 0,  2,  4, 32'h0,        32'h0,        0, 0);
        add(0, 0, 4'h0, 32'h0,        1, 4, 0,  2,  4, 32'h0,        32'h0,        1, 0);
        add(0, 0, 4'h0, 32'h0,        1, 6, 1,  2,  4, 32'h0,        32'h0,        1, 1);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  6,  2, 32'h0,        32'h0,        0, 0);
        add(0, 0, 4'h0, 32'h0,        0, 0, 0,  4,  6, 32'h0,        32'h0,        0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].we, vt[i].wn, vt[i].wbe, vt[i].d, vt[i].iss, vt[i].iss_rd,
                  vt[i].flush, vt[i].rn0, vt[i].rn1);
            #1;
            check($sformatf("vec%0d_q0", i), q[31:0], vt[i].q0);
            check($sformatf("vec%0d_q1", i), q[63:32], vt[i].q1);
            check($sformatf("vec%0d_busy", i), {30'h0, busy}, {30'h0, vt[i].b1, vt[i].b0});
        end

        // Async reset between clock edges: r9 and r7 hold data, r3 pending
        @(negedge clk);
        drive(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd9, 5'd7);
        @(negedge clk);
        idle(5'd9, 5'd3);
        #1;
        check("pre_reset_q0", q[31:0], 32'h00000001);
        check("pre_reset_busy1", {31'h0, busy[1]}, 32'h1);
        #1;
        clrn = 1'b0;
        #1;
        check("async_reset_q0", q[31:0], 32'h0);
        check("async_reset_busy", {30'h0, busy}, 32'h0);
        #1;
        clrn = 1'b1;
        @(negedge clk);
        rn = {5'd7, 5'd9};
        #1;
        check("post_reset_q0", q[31:0], 32'h0);
        check("post_reset_q1", q[63:32], 32'h0);

        // Randomized traffic on a narrow address window to force collisions
        model_clear();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 4'($urandom),
                  $urandom, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 15) == 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            check($sformatf("rnd%0d_q0", c), q[31:0], model_q(int'(rn[4:0])));
            check($sformatf("rnd%0d_q1", c), q[63:32], model_q(int'(rn[9:5])));
            check($sformatf("rnd%0d_busy", c), {30'h0, busy},
                  {30'h0, model_busy(int'(rn[9:5])), model_busy(int'(rn[4:0]))});
            @(posedge clk);
            model_edge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
